l2_req_arbiter: RTL and testbench
=================================

# l2_req_arbiter

Arbitrates and sequences requests from three sources onto the single-ported L2 cache core: the snoop port, the L1 data cache and the L1 instruction cache. Only one transaction is outstanding at a time. The block decodes trace commands into core requests, holds each request until the core accepts it, waits for the lookup result, and routes the response back to the source. It also keeps the read, write and hit statistics used for the hit-ratio report.

## Interface
Parameters:
- ADDR_W, 32, address width
- MAX_SNP_STREAK, 4, consecutive snoop grants allowed while an L1 request waits (range 1..7)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- snp_req_valid / snp_req_ready  in / out  1  snoop request handshake
- snp_req_cmd  in  4  snoop command; only 3 = invalidate, 4 = read, 5 = write, 6 = RFO are legal
- snp_req_addr  in  ADDR_W  snoop address
- l1d_req_valid / l1d_req_ready  in / out  1  L1 data request handshake
- l1d_req_wr  in  1  0 = data read (cmd 0), 1 = data write (cmd 1)
- l1d_req_addr  in  ADDR_W
- l1i_req_valid / l1i_req_ready  in / out  1  L1 instruction read handshake (cmd 2)
- l1i_req_addr  in  ADDR_W
- cc_req_valid  out  1  request to the cache core
- cc_req_ready  in  1  core accepts the request
- cc_req_cmd  out  4  decoded command, values 0..6
- cc_req_addr  out  ADDR_W
- cc_rsp_valid  in  1  core lookup done, single-cycle pulse
- cc_rsp_hit  in  1  lookup hit
- rsp_valid  out  1  response to the source, single-cycle pulse
- rsp_src  out  2  source of the response: 0 = snoop, 1 = L1D, 2 = L1I
- rsp_hit  out  1
- err_illegal  out  1  one-cycle pulse when an illegal snoop command is accepted
- stat_clear  in  1  clears the statistics counters (ClearCache)
- stat_read, stat_write, stat_hit  out  32  statistics counters

## Operation
FSM states are IDLE, ISSUE and WAIT.

IDLE:
- Exactly one `*_req_ready` is high: the one for the arbitration winner. It is a combinational function of the valids, the state, `streak` and `last_l1`.
- All `*_req_ready` are low when no source is valid, and in every non-IDLE state.
- Arbitration:
  - Snoop wins, unless any L1 request is valid and `streak == MAX_SNP_STREAK`.
  - Between L1D and L1I, round-robin: the source not recorded in `last_l1` wins when both are valid.
- On a handshake: latch cmd, addr and src, then go to ISSUE.
- Exception: an illegal snoop cmd is accepted and dropped. `err_illegal` pulses the next cycle, the state stays IDLE, and `streak` is unchanged.

Fairness state:
- `streak` (3-bit): incremented on each snoop grant while any L1 valid is high; cleared on any L1 grant.
- `last_l1` toggles to the granted L1 source on every L1 grant.

ISSUE:
- `cc_req_valid = 1` with the latched cmd and addr, held stable until `cc_req_ready`.
- On `cc_req_ready`, go to WAIT.

WAIT:
- On `cc_rsp_valid`, go to IDLE.
- In the same edge, register `rsp_valid = 1`, `rsp_src` and `rsp_hit`; these are visible the following cycle.

Statistics (updated on the edge that registers `rsp_valid`):
- `stat_read` += 1 for cmd 0 or 2.
- `stat_write` += 1 for cmd 1.
- `stat_hit` += 1 for an L1 source with hit.
- Snoop responses never count.
- Counters saturate at 0xFFFFFFFF.
- `stat_clear` zeroes all three and wins over a simultaneous increment.

Other rules:
- `cc_rsp_valid` outside WAIT is ignored.
- Sources must hold valid, cmd and addr stable until their ready is seen.

## Timing
Reset values:
- state = IDLE; `streak = 0`; `last_l1 = L1I`, so L1D wins the first tie.
- `cc_req_valid`, `rsp_valid`, `err_illegal` = 0; `cc_req_cmd`, `cc_req_addr`, `rsp_src`, `rsp_hit` = 0; all stats = 0.

Latency and throughput:
- Accept at cycle N, `cc_req_valid` at N+1.
- With the core ready and responding at N+2, `rsp_valid` is seen at N+3 and the next accept can happen at N+3.
- Minimum spacing between grants is 3 cycles.

Reset mid-transaction (asserted in ISSUE or WAIT):
- The next cycle is IDLE with `cc_req_valid = 0`.
- The pending response is dropped: no `rsp_valid`, no stats update.

`stat_clear` during a transaction does not disturb the FSM.

## Test plan
- **Single L1D read, miss.** L1D read 0x0000_1040; core ready immediately, `cc_rsp_valid` 1 cycle later with hit = 0. Expect `cc_req_cmd = 0` at cycle 1, `rsp_valid` at cycle 3 with `rsp_src = 1`, `rsp_hit = 0`, `stat_read = 1`, `stat_hit = 0`.
- **Three sources valid at once.** Snoop cmd 4, L1D write, L1I read. Expect grant order snoop, L1D, L1I. The snoop response does not change the stats; then `stat_write = 1` and `stat_read = 1`.
- **Snoop flood with L1I waiting.** Snoops stay continuously valid while L1I waits (MAX_SNP_STREAK = 4). Expect 4 snoop grants, then the L1I grant, then snoops resume.
- **Illegal snoop cmd.** Snoop cmd 9. Expect `snp_req_ready` high for 1 cycle, `err_illegal` pulse, no `cc_req_valid`, state remains IDLE.
- **Backpressure plus reset.** Hold `cc_req_ready = 0` for 5 cycles; `cc_req_valid`, cmd and addr must stay stable. Then raise `cc_req_ready`, and assert `rst` in WAIT. Expect no `rsp_valid`, and a later `cc_rsp_valid` is ignored.
- **Counter saturation and clear.** Preload `stat_read` to 0xFFFFFFFF and complete an L1I read: it stays at 0xFFFFFFFF. Then assert `stat_clear` on the edge where a response registers: all stats read 0.

Source files
------------

// File: rtl/l2_req_arbiter_if.sv
// l2_req_arbiter_if
//   Request/response bundle between the three request sources, the L2 cache
//   core and l2_req_arbiter.
//   snp_req_*  : snoop request handshake (valid/ready, cmd, addr)
//   l1d_req_*  : L1 data request handshake (valid/ready, wr, addr)
//   l1i_req_*  : L1 instruction read handshake (valid/ready, addr)
//   cc_req_*   : request to the cache core (valid/ready, cmd, addr)
//   cc_rsp_*   : lookup-done pulse and hit flag from the core
//   rsp_*      : response pulse routed back to the source (src, hit)
//   Modport slave is the arbiter side, master is the sources/core side.
interface l2_req_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              snp_req_valid;
  logic              snp_req_ready;
  logic [3:0]        snp_req_cmd;
  logic [ADDR_W-1:0] snp_req_addr;

  logic              l1d_req_valid;
  logic              l1d_req_ready;
  logic              l1d_req_wr;
  logic [ADDR_W-1:0] l1d_req_addr;

  logic              l1i_req_valid;
  logic              l1i_req_ready;
  logic [ADDR_W-1:0] l1i_req_addr;

  logic              cc_req_valid;
  logic              cc_req_ready;
  logic [3:0]        cc_req_cmd;
  logic [ADDR_W-1:0] cc_req_addr;
  logic              cc_rsp_valid;
  logic              cc_rsp_hit;

  logic              rsp_valid;
  logic [1:0]        rsp_src;
  logic              rsp_hit;

  modport slave (
    input  snp_req_valid, snp_req_cmd, snp_req_addr,
    output snp_req_ready,
    input  l1d_req_valid, l1d_req_wr, l1d_req_addr,
    output l1d_req_ready,
    input  l1i_req_valid, l1i_req_addr,
    output l1i_req_ready,
    output cc_req_valid, cc_req_cmd, cc_req_addr,
    input  cc_req_ready, cc_rsp_valid, cc_rsp_hit,
    output rsp_valid, rsp_src, rsp_hit
  );

  modport master (
    output snp_req_valid, snp_req_cmd, snp_req_addr,
    input  snp_req_ready,
    output l1d_req_valid, l1d_req_wr, l1d_req_addr,
    input  l1d_req_ready,
    output l1i_req_valid, l1i_req_addr,
    input  l1i_req_ready,
    input  cc_req_valid, cc_req_cmd, cc_req_addr,
    output cc_req_ready, cc_rsp_valid, cc_rsp_hit,
    input  rsp_valid, rsp_src, rsp_hit
  );
endinterface

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter
//   Arbitrates snoop, L1D and L1I requests onto the single-ported L2 core,
//   one transaction outstanding at a time (IDLE -> ISSUE -> WAIT), routes the
//   lookup result back to the source and keeps read/write/hit statistics.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : request/response bundle (slave modport)
//   err_illegal  : one-cycle pulse after an illegal snoop cmd is dropped
//   stat_clear   : zeroes the statistics, wins over a same-cycle increment
//   stat_read/stat_write/stat_hit : saturating 32-bit statistics
module l2_req_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int MAX_SNP_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  l2_req_arbiter_if.slave      bus,
  output logic                 err_illegal,
  input  logic                 stat_clear,
  output logic [31:0]          stat_read,
  output logic [31:0]          stat_write,
  output logic [31:0]          stat_hit
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  localparam logic [1:0] SRC_SNP    = 2'd0;
  localparam logic [1:0] SRC_L1D    = 2'd1;
  localparam logic [1:0] SRC_L1I    = 2'd2;
  localparam logic [2:0] STREAK_MAX = 3'(MAX_SNP_STREAK);

  state_e            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        src_q, src_d;
  logic [2:0]        streak_q, streak_d;
  logic              last_l1_q, last_l1_d;   // 1 = L1I was the last L1 grant
  logic              cc_req_valid_q, cc_req_valid_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_src_q, rsp_src_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic              err_q, err_d;
  logic [31:0]       stat_read_q, stat_read_d;
  logic [31:0]       stat_write_q, stat_write_d;
  logic [31:0]       stat_hit_q, stat_hit_d;

  logic any_l1, snp_win, l1d_win, l1i_win, snp_legal;
  logic inc_read, inc_write, inc_hit;

  // Arbitration: snoop first unless it has starved a waiting L1 source for
  // MAX_SNP_STREAK grants; L1D/L1I alternate on a tie.
  always_comb begin
    any_l1    = bus.l1d_req_valid | bus.l1i_req_valid;
    snp_win   = bus.snp_req_valid && !(any_l1 && (streak_q == STREAK_MAX));
    l1d_win   = !snp_win && bus.l1d_req_valid && (!bus.l1i_req_valid || last_l1_q);
    l1i_win   = !snp_win && bus.l1i_req_valid && !l1d_win;
    snp_legal = (bus.snp_req_cmd >= 4'd3) && (bus.snp_req_cmd <= 4'd6);

    bus.snp_req_ready = (state_q == IDLE) && snp_win;
    bus.l1d_req_ready = (state_q == IDLE) && l1d_win;
    bus.l1i_req_ready = (state_q == IDLE) && l1i_win;
  end

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    addr_d         = addr_q;
    src_d          = src_q;
    streak_d       = streak_q;
    last_l1_d      = last_l1_q;
    cc_req_valid_d = cc_req_valid_q;
    rsp_valid_d    = 1'b0;
    rsp_src_d      = rsp_src_q;
    rsp_hit_d      = rsp_hit_q;
    err_d          = 1'b0;
    inc_read       = 1'b0;
    inc_write      = 1'b0;
    inc_hit        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.snp_req_ready) begin
          if (snp_legal) begin
            cmd_d          = bus.snp_req_cmd;
            addr_d         = bus.snp_req_addr;
            src_d          = SRC_SNP;
            cc_req_valid_d = 1'b1;
            state_d        = ISSUE;
            if (any_l1) streak_d = streak_q + 3'd1;
          end else begin
            // Illegal snoop is consumed without touching fairness state.
            err_d = 1'b1;
          end
        end else if (bus.l1d_req_ready) begin
          cmd_d          = {3'b000, bus.l1d_req_wr};
          addr_d         = bus.l1d_req_addr;
          src_d          = SRC_L1D;
          streak_d       = '0;
          last_l1_d      = 1'b0;
          cc_req_valid_d = 1'b1;
          state_d        = ISSUE;
        end else if (bus.l1i_req_ready) begin
          cmd_d          = 4'd2;
          addr_d         = bus.l1i_req_addr;
          src_d          = SRC_L1I;
          streak_d       = '0;
          last_l1_d      = 1'b1;
          cc_req_valid_d = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.cc_req_ready) begin
          cc_req_valid_d = 1'b0;
          state_d        = WAIT;
        end
      end
      WAIT: begin
        if (bus.cc_rsp_valid) begin
          rsp_valid_d = 1'b1;
          rsp_src_d   = src_q;
          rsp_hit_d   = bus.cc_rsp_hit;
          state_d     = IDLE;
          inc_read    = (cmd_q == 4'd0) || (cmd_q == 4'd2);
          inc_write   = (cmd_q == 4'd1);
          inc_hit     = (src_q != SRC_SNP) && bus.cc_rsp_hit;
        end
      end
      default: state_d = IDLE;
    endcase

    stat_read_d  = stat_read_q;
    stat_write_d = stat_write_q;
    stat_hit_d   = stat_hit_q;
    if (stat_clear) begin
      stat_read_d  = '0;
      stat_write_d = '0;
      stat_hit_d   = '0;
    end else begin
      if (inc_read  && (stat_read_q  != '1)) stat_read_d  = stat_read_q  + 32'd1;
      if (inc_write && (stat_write_q != '1)) stat_write_d = stat_write_q + 32'd1;
      if (inc_hit   && (stat_hit_q   != '1)) stat_hit_d   = stat_hit_q   + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      addr_q         <= '0;
      src_q          <= '0;
      streak_q       <= '0;
      last_l1_q      <= 1'b1;
      cc_req_valid_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_src_q      <= '0;
      rsp_hit_q      <= 1'b0;
      err_q          <= 1'b0;
      stat_read_q    <= '0;
      stat_write_q   <= '0;
      stat_hit_q     <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      addr_q         <= addr_d;
      src_q          <= src_d;
      streak_q       <= streak_d;
      last_l1_q      <= last_l1_d;
      cc_req_valid_q <= cc_req_valid_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_src_q      <= rsp_src_d;
      rsp_hit_q      <= rsp_hit_d;
      err_q          <= err_d;
      stat_read_q    <= stat_read_d;
      stat_write_q   <= stat_write_d;
      stat_hit_q     <= stat_hit_d;
    end
  end

  assign bus.cc_req_valid = cc_req_valid_q;
  assign bus.cc_req_cmd   = cmd_q;
  assign bus.cc_req_addr  = addr_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_src      = rsp_src_q;
  assign bus.rsp_hit      = rsp_hit_q;
  assign err_illegal      = err_q;
  assign stat_read        = stat_read_q;
  assign stat_write       = stat_write_q;
  assign stat_hit         = stat_hit_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter
//   Directed bench for l2_req_arbiter: single read, three-way arbitration,
//   snoop streak limit, illegal snoop, backpressure with reset, statistics
//   saturation and clear.
module tb_l2_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_illegal;
  logic        stat_clear;
  logic [31:0] stat_read, stat_write, stat_hit;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  l2_req_arbiter_if #(.ADDR_W(32)) bus ();

  l2_req_arbiter #(.ADDR_W(32), .MAX_SNP_STREAK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_illegal (err_illegal),
    .stat_clear  (stat_clear),
    .stat_read   (stat_read),
    .stat_write  (stat_write),
    .stat_hit    (stat_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the cycle after a grant (ISSUE): core accepts at once and
  // responds one cycle later; returns in the cycle where rsp_valid shows.
  task automatic serve(input string tag, input logic [3:0] cmd, input logic [31:0] addr,
                       input logic [1:0] src, input logic hit, input logic clr);
    chk({tag, ".ccv"},  {31'd0, bus.cc_req_valid}, 32'd1);
    chk({tag, ".cmd"},  {28'd0, bus.cc_req_cmd}, {28'd0, cmd});
    chk({tag, ".addr"}, bus.cc_req_addr, addr);
    bus.cc_req_ready = 1'b1;
    step;
    bus.cc_req_ready = 1'b0;
    chk({tag, ".ccv_wait"}, {31'd0, bus.cc_req_valid}, 32'd0);
    bus.cc_rsp_valid = 1'b1;
    bus.cc_rsp_hit   = hit;
    stat_clear       = clr;
    step;
    bus.cc_rsp_valid = 1'b0;
    bus.cc_rsp_hit   = 1'b0;
    stat_clear       = 1'b0;
    chk({tag, ".rspv"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({tag, ".src"},  {30'd0, bus.rsp_src}, {30'd0, src});
    chk({tag, ".hit"},  {31'd0, bus.rsp_hit}, {31'd0, hit});
  endtask

  task automatic chk_ready(input string tag, input logic s, input logic d, input logic i);
    chk({tag, ".rdy"}, {29'd0, bus.snp_req_ready, bus.l1d_req_ready, bus.l1i_req_ready},
        {29'd0, s, d, i});
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] r, input logic [31:0] w,
                           input logic [31:0] h);
    chk({tag, ".st_rd"}, stat_read, r);
    chk({tag, ".st_wr"}, stat_write, w);
    chk({tag, ".st_hit"}, stat_hit, h);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stat_clear = 1'b0;
    bus.snp_req_valid = 1'b0; bus.snp_req_cmd = 4'd0; bus.snp_req_addr = '0;
    bus.l1d_req_valid = 1'b0; bus.l1d_req_wr  = 1'b0; bus.l1d_req_addr = '0;
    bus.l1i_req_valid = 1'b0; bus.l1i_req_addr = '0;
    bus.cc_req_ready  = 1'b0; bus.cc_rsp_valid = 1'b0; bus.cc_rsp_hit = 1'b0;
    do_reset;

    // Reset state
    chk("rst.ccv",  {31'd0, bus.cc_req_valid}, 32'd0);
    chk("rst.cmd",  {28'd0, bus.cc_req_cmd}, 32'd0);
    chk("rst.addr", bus.cc_req_addr, 32'd0);
    chk("rst.rspv", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst.src",  {30'd0, bus.rsp_src}, 32'd0);
    chk("rst.err",  {31'd0, err_illegal}, 32'd0);
    chk_ready("rst", 1'b0, 1'b0, 1'b0);
    chk_stats("rst", 32'd0, 32'd0, 32'd0);

    // Single L1D read, miss
    bus.l1d_req_valid = 1'b1; bus.l1d_req_wr = 1'b0; bus.l1d_req_addr = 32'h0000_1040;
    #1 chk_ready("t1", 1'b0, 1'b1, 1'b0);
    step;
    bus.l1d_req_valid = 1'b0;
    chk_ready("t1.busy", 1'b0, 1'b0, 1'b0);
    serve("t1", 4'd0, 32'h0000_1040, 2'd1, 1'b0, 1'b0);
    chk_stats("t1", 32'd1, 32'd0, 32'd0);
    step;
    chk("t1.pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // Three sources at once: snoop, then L1D (first tie after reset), then L1I
    do_reset;
    chk_stats("t2.rst", 32'd0, 32'd0, 32'd0);
    bus.snp_req_valid = 1'b1; bus.snp_req_cmd = 4'd4; bus.snp_req_addr = 32'hA000_0000;
    bus.l1d_req_valid = 1'b1; bus.l1d_req_wr = 1'b1; bus.l1d_req_addr = 32'hB000_0010;
    bus.l1i_req_valid = 1'b1; bus.l1i_req_addr = 32'hC000_0020;
    #1 chk_ready("t2.g0", 1'b1, 1'b0, 1'b0);
    step;
    bus.snp_req_valid = 1'b0;
    serve("t2.snp", 4'd4, 32'hA000_0000, 2'd0, 1'b1, 1'b0);
    chk_stats("t2.snp", 32'd0, 32'd0, 32'd0);
    chk_ready("t2.g1", 1'b0, 1'b1, 1'b0);
    step;
    bus.l1d_req_valid = 1'b0;
    serve("t2.l1d", 4'd1, 32'hB000_0010, 2'd1, 1'b1, 1'b0);
    chk_stats("t2.l1d", 32'd0, 32'd1, 32'd1);
    chk_ready("t2.g2", 1'b0, 1'b0, 1'b1);
    step;
    bus.l1i_req_valid = 1'b0;
    serve("t2.l1i", 4'd2, 32'hC000_0020, 2'd2, 1'b0, 1'b0);
    chk_stats("t2.l1i", 32'd1, 32'd1, 32'd1);

    // Snoop flood with L1I waiting: 4 snoops, then L1I, then snoops resume
    bus.snp_req_valid = 1'b1; bus.snp_req_cmd = 4'd5; bus.snp_req_addr = 32'h0000_5000;
    bus.l1i_req_valid = 1'b1; bus.l1i_req_addr = 32'h0000_6000;
    for (int i = 0; i < 4; i++) begin
      #1 chk_ready($sformatf("t3.s%0d", i), 1'b1, 1'b0, 1'b0);
      step;
      serve($sformatf("t3.s%0d", i), 4'd5, 32'h0000_5000, 2'd0, 1'b1, 1'b0);
    end
    chk_ready("t3.l1i", 1'b0, 1'b0, 1'b1);
    step;
    bus.l1i_req_valid = 1'b0;
    serve("t3.l1i", 4'd2, 32'h0000_6000, 2'd2, 1'b1, 1'b0);
    chk_ready("t3.resume", 1'b1, 1'b0, 1'b0);
    step;
    bus.snp_req_valid = 1'b0;
    serve("t3.s4", 4'd5, 32'h0000_5000, 2'd0, 1'b0, 1'b0);
    chk_stats("t3", 32'd2, 32'd1, 32'd2);

    // Illegal snoop command: dropped, err pulse, stays IDLE
    bus.snp_req_valid = 1'b1; bus.snp_req_cmd = 4'd9; bus.snp_req_addr = 32'h0000_9999;
    #1 chk_ready("t4", 1'b1, 1'b0, 1'b0);
    step;
    bus.snp_req_valid = 1'b0;
    chk("t4.err", {31'd0, err_illegal}, 32'd1);
    chk("t4.ccv", {31'd0, bus.cc_req_valid}, 32'd0);
    bus.l1d_req_valid = 1'b1; bus.l1d_req_wr = 1'b0; bus.l1d_req_addr = 32'h0000_7000;
    #1 chk_ready("t4.idle", 1'b0, 1'b1, 1'b0);
    step;
    bus.l1d_req_valid = 1'b0;
    chk("t4.err_off", {31'd0, err_illegal}, 32'd0);
    serve("t4.l1d", 4'd0, 32'h0000_7000, 2'd1, 1'b0, 1'b0);
    chk_stats("t4", 32'd3, 32'd1, 32'd2);

    // Backpressure for 5 cycles, then reset while waiting for the lookup
    bus.l1i_req_valid = 1'b1; bus.l1i_req_addr = 32'h0000_8888;
    #1 chk_ready("t5", 1'b0, 1'b0, 1'b1);
    step;
    bus.l1i_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5.bp%0d.ccv", i), {31'd0, bus.cc_req_valid}, 32'd1);
      chk($sformatf("t5.bp%0d.cmd", i), {28'd0, bus.cc_req_cmd}, 32'd2);
      chk($sformatf("t5.bp%0d.addr", i), bus.cc_req_addr, 32'h0000_8888);
      step;
    end
    chk("t5.hold.ccv", {31'd0, bus.cc_req_valid}, 32'd1);
    bus.cc_req_ready = 1'b1;
    step;
    bus.cc_req_ready = 1'b0;
    chk("t5.wait.ccv", {31'd0, bus.cc_req_valid}, 32'd0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("t5.rst.ccv",  {31'd0, bus.cc_req_valid}, 32'd0);
    chk("t5.rst.rspv", {31'd0, bus.rsp_valid}, 32'd0);
    bus.cc_rsp_valid = 1'b1; bus.cc_rsp_hit = 1'b1;
    step;
    bus.cc_rsp_valid = 1'b0; bus.cc_rsp_hit = 1'b0;
    chk("t5.late.rspv", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t5.late.ccv",  {31'd0, bus.cc_req_valid}, 32'd0);
    chk_stats("t5", 32'd0, 32'd0, 32'd0);

    // Saturation: preload stat_read, complete an L1I read
    force dut.stat_read_q = 32'hFFFF_FFFF;
    #1 release dut.stat_read_q;
    chk("t6.preload", stat_read, 32'hFFFF_FFFF);
    bus.l1i_req_valid = 1'b1; bus.l1i_req_addr = 32'h0000_0F00;
    #1 chk_ready("t6", 1'b0, 1'b0, 1'b1);
    step;
    bus.l1i_req_valid = 1'b0;
    serve("t6.l1i", 4'd2, 32'h0000_0F00, 2'd2, 1'b1, 1'b0);
    chk_stats("t6.sat", 32'hFFFF_FFFF, 32'd0, 32'd1);

    // Clear on the response edge wins over the write/hit increment
    bus.l1d_req_valid = 1'b1; bus.l1d_req_wr = 1'b1; bus.l1d_req_addr = 32'h0000_0E00;
    #1 chk_ready("t6.clr", 1'b0, 1'b1, 1'b0);
    step;
    bus.l1d_req_valid = 1'b0;
    serve("t6.clr", 4'd1, 32'h0000_0E00, 2'd1, 1'b1, 1'b1);
    chk_stats("t6.clr", 32'd0, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
